// File: rtl/stack_pkg.sv
// stack_pkg: shared op-codes, FSM state type, parameter defaults and byte-lane helpers
package stack_pkg;
    localparam logic [7:0] DEF_STACK_PAGE = 8'h01;
    localparam logic [7:0] DEF_S_RESET = 8'hFD;
    localparam logic [2:0] OP_PUSH1 = 3'd0;
    localparam logic [2:0] OP_PULL1 = 3'd1;
    localparam logic [2:0] OP_PUSH2 = 3'd2;
    localparam logic [2:0] OP_PULL2 = 3'd3;
    localparam logic [2:0] OP_PUSH3 = 3'd4;
    localparam logic [2:0] OP_PULL3 = 3'd5;
    localparam logic [2:0] OP_LOAD_S = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE} state_t;
    // Index of the last byte of a transfer op: op[2:1] is 0, 1, 2 for 1, 2, 3 bytes.
    function automatic logic [1:0] op_last(input logic [2:0] op);
        return op[2:1];
    endfunction
    // Byte lane (0=p, 1=lo, 2=hi) touched by byte idx of op.
    // Pushes go hi first, pulls go in reverse; single-byte ops use p only.
    function automatic logic [1:0] op_lane(input logic [2:0] op, input logic [1:0] idx);
        return op[0] ? ((op[2:1] == 2'd1) ? idx + 2'd1 : idx)
                     : ((op[2:1] == 2'd0) ? 2'd0 : 2'd2 - idx);
    endfunction
endpackage

// File: rtl/stack_ptr.sv
// stack_ptr: 8-bit stack pointer register with load/inc/dec (load wins), modulo-256
// Ports: clk, rst (async, active-high), inc, dec, load, load_val[7:0], s[7:0]
module stack_ptr #(
    parameter logic [7:0] S_RESET = 8'hFD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] s
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= S_RESET;
        else if (load) s <= load_val;
        else if (inc) s <= s + 8'd1;
        else if (dec) s <= s - 8'd1;
    end
endmodule

// File: rtl/stack_engine.sv
// stack_engine: 6502-style hardware stack engine issuing byte push/pull memory cycles
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_op[2:0]/cmd_data[23:0] command;
//        mem_req/mem_we/mem_addr[15:0]/mem_wdata[7:0]/mem_ack/mem_rdata[7:0] memory handshake;
//        done (1-cycle pulse), rsp_data[23:0] {hi,lo,p}, s_out[7:0], wrap_err (sticky).
// Macro: STACK_WRAP_CHECK_EN enables the wrap_err detector; otherwise wrap_err is tied to 0.
module stack_engine
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = DEF_STACK_PAGE,
    parameter logic [7:0] S_RESET = DEF_S_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [23:0] cmd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        done,
    output logic [23:0] rsp_data,
    output logic [7:0]  s_out,
    output logic        wrap_err
);
    state_t state;
    logic [2:0] op;
    logic [23:0] data;
    logic [1:0] idx;
    logic [1:0] lane;
    logic [7:0] s;
    logic accept, ack, push;
    assign cmd_ready = state == ST_IDLE;
    assign accept = cmd_valid && cmd_ready;
    // mem_ack only counts while a request is outstanding
    assign ack = mem_req && mem_ack;
    assign push = !op[0];
    assign lane = op_lane(op, idx);
    assign mem_req = state == ST_XFER;
    assign mem_we = push;
    // Pushes write at S then decrement; pulls pre-increment, so they read S+1
    assign mem_addr = {STACK_PAGE, push ? s : s + 8'd1};
    assign mem_wdata = (lane == 2'd2) ? data[23:16] : (lane == 2'd1) ? data[15:8] : data[7:0];
    assign done = state == ST_DONE;
    assign s_out = s;
    stack_ptr #(.S_RESET(S_RESET)) u_ptr (
        .clk(clk),
        .rst(rst),
        .inc(ack && !push),
        .dec(ack && push),
        .load(accept && cmd_op == OP_LOAD_S),
        .load_val(cmd_data[7:0]),
        .s(s)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op <= '0;
            data <= '0;
            idx <= '0;
            rsp_data <= '0;
        end else if (accept) begin
            op <= cmd_op;
            data <= cmd_data;
            idx <= '0;
            // LOAD_S and the reserved op have no memory phase
            state <= (cmd_op[2:1] == 2'b11) ? ST_DONE : ST_XFER;
        end else if (ack) begin
            idx <= idx + 2'd1;
            state <= (idx == op_last(op)) ? ST_DONE : ST_XFER;
            if (!push) rsp_data[{lane, 3'b000} +: 8] <= mem_rdata;
        end else if (state == ST_DONE) begin
            state <= ST_IDLE;
        end
    end
`ifdef STACK_WRAP_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap_err <= 1'b0;
        else if (accept && cmd_op == OP_LOAD_S) wrap_err <= 1'b0;
        else if (ack && (push ? s == 8'h00 : s == 8'hFF)) wrap_err <= 1'b1;
    end
`else
    assign wrap_err = 1'b0;
`endif
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: randomized self-checking bench for stack_engine against a stack-level model
module tb_stack_engine;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  dat;
    } txn_t;
`ifdef STACK_WRAP_CHECK_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [23:0] cmd_data = '0;
    logic mem_req, mem_we, mem_ack = 1'b0, done, wrap_err;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata = '0, s_out;
    logic [23:0] rsp_data;
    int checks = 0;
    int failures = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit junk_ack = 1'b0;
    logic [7:0] resp_mem [256];
    txn_t log_q[$];
    txn_t exp_q[$];
    logic [7:0] m_mem [256];
    logic [7:0] m_s;
    logic [23:0] m_rsp;
    logic m_wrap;
    // byte lanes (0=p,1=lo,2=hi) in transfer order, indexed by byte count-1
    int push_order [3][3] = '{'{0, 0, 0}, '{2, 1, 0}, '{2, 1, 0}};
    int pull_order [3][3] = '{'{0, 0, 0}, '{1, 2, 0}, '{0, 1, 2}};

    stack_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .rsp_data(rsp_data), .s_out(s_out), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    // memory responder: ack after ack_delay wait cycles, random junk acks while idle
    always @(negedge clk) begin
        mem_ack <= mem_req ? (wait_cnt >= ack_delay) : junk_ack;
        mem_rdata <= resp_mem[mem_addr[7:0]];
    end
    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            log_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
            if (mem_we) resp_mem[mem_addr[7:0]] <= mem_wdata;
            wait_cnt <= 0;
        end else begin
            wait_cnt <= mem_req ? wait_cnt + 1 : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 8'hFD;
        m_rsp = '0;
        m_wrap = 1'b0;
    endtask

    // stack-level behaviour: push stores at S then S--, pull does S++ then reads
    task automatic model_op(input logic [2:0] op, input logic [23:0] d);
        int k, lane;
        logic [7:0] b;
        if (op == 3'd6) begin
            m_s = d[7:0];
            m_wrap = 1'b0;
        end else if (op != 3'd7) begin
            k = int'(op) / 2;
            for (int i = 0; i <= k; i++) begin
                if (op[0] == 1'b0) begin
                    lane = push_order[k][i];
                    b = d[lane*8 +: 8];
                    if (m_s == 8'h00 && WRAP_EN) m_wrap = 1'b1;
                    exp_q.push_back({1'b1, 8'h01, m_s, b});
                    m_mem[m_s] = b;
                    m_s = m_s - 8'd1;
                end else begin
                    lane = pull_order[k][i];
                    if (m_s == 8'hFF && WRAP_EN) m_wrap = 1'b1;
                    m_s = m_s + 8'd1;
                    b = m_mem[m_s];
                    exp_q.push_back({1'b0, 8'h01, m_s, b});
                    m_rsp[lane*8 +: 8] = b;
                end
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [23:0] d, input int dly);
        int cyc, n;
        ack_delay = dly;
        log_q.delete();
        exp_q.delete();
        model_op(op, d);
        n = exp_q.size();
        @(negedge clk);
        check("ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data = 24'($urandom);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (done) break;
            cyc++;
        end
        check("done_seen", 32'(done), 1);
        check("latency", 32'(cyc), 32'(n * (dly + 1)));
        check("txn_count", 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < log_q.size()) check($sformatf("txn%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
        check("rsp_data", 32'(rsp_data), 32'(m_rsp));
        check("s_out", 32'(s_out), 32'(m_s));
        check("wrap_err", 32'(wrap_err), 32'(m_wrap));
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [23:0] rd;
        int seen;
        for (int i = 0; i < 256; i++) begin
            resp_mem[i] = 8'($urandom);
            m_mem[i] = resp_mem[i];
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_out", 32'(s_out), 32'h0FD);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rsp", 32'(rsp_data), 0);
        check("rst_wrap", 32'(wrap_err), 0);

        // PUSH2 at FD, zero-wait
        run_op(3'd2, 24'h123456, 0);
        check("push2_b0", 32'(log_q[0]), 32'({1'b1, 16'h01FD, 8'h12}));
        check("push2_b1", 32'(log_q[1]), 32'({1'b1, 16'h01FC, 8'h34}));
        check("push2_s", 32'(s_out), 32'h0FB);

        // PULL3 at FA with 2-cycle ack delay
        run_op(3'd6, 24'h0000FA, 0);
        resp_mem[8'hFB] = 8'hA5; m_mem[8'hFB] = 8'hA5;
        resp_mem[8'hFC] = 8'h34; m_mem[8'hFC] = 8'h34;
        resp_mem[8'hFD] = 8'h12; m_mem[8'hFD] = 8'h12;
        run_op(3'd5, 24'h0, 2);
        check("pull3_a0", 32'(log_q[0].addr), 32'h01FB);
        check("pull3_a1", 32'(log_q[1].addr), 32'h01FC);
        check("pull3_a2", 32'(log_q[2].addr), 32'h01FD);
        check("pull3_rsp", 32'(rsp_data), 32'h1234A5);
        check("pull3_s", 32'(s_out), 32'h0FD);

        // wrap-around push at S=00
        run_op(3'd6, 24'h000000, 0);
        run_op(3'd0, 24'h000077, 0);
        check("wrap_txn", 32'(log_q[0]), 32'({1'b1, 16'h0100, 8'h77}));
        check("wrap_s", 32'(s_out), 32'h0FF);
        check("wrap_flag", 32'(wrap_err), 32'(WRAP_EN));
        run_op(3'd7, 24'h0, 0);
        check("rsvd_keeps_wrap", 32'(wrap_err), 32'(WRAP_EN));
        run_op(3'd6, 24'h0000FD, 0);

        // reset during second byte of PUSH3
        ack_delay = 1;
        log_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 24'hC1D2E3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (log_q.size() != 0) break;
        end
        check("mid_first_ack", 32'(log_q.size()), 1);
        check("mid_req_before", 32'(mem_req), 1);
        #1 rst = 1'b1;
        #1 check("mid_req_rst", 32'(mem_req), 0);
        check("mid_s_rst", 32'(s_out), 32'h0FD);
        m_mem[8'hFD] = 8'hC1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || mem_req) seen++;
        end
        check("mid_no_done", 32'(seen), 0);
        check("mid_txns", 32'(log_q.size()), 1);
        check("mid_s", 32'(s_out), 32'h0FD);

        // backpressure: cmd_valid held through a busy op
        ack_delay = 0;
        log_q.delete();
        exp_q.delete();
        model_op(3'd0, 24'h00005A);
        model_op(3'd0, 24'h0000C3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 24'h00005A;
        @(negedge clk);
        check("bp_busy_ready", 32'(cmd_ready), 0);
        check("bp_busy_req", 32'(mem_req), 1);
        @(negedge clk);
        check("bp_done", 32'(done), 1);
        check("bp_done_ready", 32'(cmd_ready), 0);
        cmd_data = 24'h0000C3;
        @(negedge clk);
        check("bp_idle_ready", 32'(cmd_ready), 1);
        check("bp_idle_req", 32'(mem_req), 0);
        @(negedge clk);
        check("bp_second_req", 32'(mem_req), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_second_done", 32'(done), 1);
        @(negedge clk);
        check("bp_txns", 32'(log_q.size()), 2);
        check("bp_txn0", 32'(log_q[0]), 32'(exp_q[0]));
        check("bp_txn1", 32'(log_q[1]), 32'(exp_q[1]));
        check("bp_s", 32'(s_out), 32'(m_s));

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            rop = 3'($urandom_range(0, 7));
            rd = 24'($urandom);
            if (rop == 3'd6) begin
                case ($urandom_range(0, 4))
                    0: rd[7:0] = 8'h00;
                    1: rd[7:0] = 8'hFF;
                    2: rd[7:0] = 8'h01;
                    3: rd[7:0] = 8'hFE;
                    default: ;
                endcase
            end
            junk_ack = 1'($urandom_range(0, 1));
            run_op(rop, rd, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
